led_mode_ctrl: RTL and testbench
================================

Name: led_mode_ctrl

Overview:
- Controller for the 4-LED board output.
- Owns the step prescaler and the LED pattern register.
- Two command requesters share it through a fixed-priority valid/ready arbiter: A is high priority (e.g. key decoder), B is low priority (e.g. UART command path).
- Sequences one of several display modes: rotate right, rotate left, blink all, ping-pong, hold, off.

Parameters:
- STEP_CYCLES, 50_000_000, sys_clk cycles per pattern step; legal range >= 2.
- CNT_W, $clog2(STEP_CYCLES), prescaler counter width; derived, not overridden.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  reset, synchronous, active-high.
- a_valid  in  1  requester A command valid.
- a_cmd  in  3  requester A command code.
- a_ready  out  1  requester A ready.
- b_valid  in  1  requester B command valid.
- b_cmd  in  3  requester B command code.
- b_ready  out  1  requester B ready.
- led  out  4  LED drive; 1 = on.
- mode  out  3  current mode code.
- tick  out  1  one-cycle pulse on each pattern step.
- cmd_err  out  1  one-cycle pulse after an illegal command is accepted.

Behaviour:
- Command codes: 0 OFF, 1 ROT_R, 2 ROT_L, 3 BLINK, 4 PING, 5 HOLD. Codes 6 and 7 are illegal.
- Ready signals are combinational:
  - a_ready = !sys_rst
  - b_ready = !sys_rst && !a_valid
- Accept = valid && ready. At most one command is accepted per cycle, and A wins.
- Reset values (synchronous):
  - mode = 1 (ROT_R), led = 0001, cnt = 0, dir = up, tick = 0, cmd_err = 0.
  - Reset overrides any same-cycle accept.
- Legal accept at edge E:
  - At E, mode takes the new code, cnt goes to 0, and led loads the entry pattern: OFF 0000, ROT_R 0001, ROT_L 0001, BLINK 1111, PING 0001 with dir = up.
  - HOLD keeps led unchanged.
  - Re-issuing the current mode restarts it from its entry pattern.
- Illegal accept at E:
  - cmd_err = 1 for the one cycle after E.
  - mode, led, cnt and dir are unchanged; the counter keeps running.
- Prescaler:
  - Runs only in ROT_R, ROT_L, BLINK and PING. In OFF and HOLD, cnt is held at 0 and tick = 0.
  - cnt increments each cycle. When cnt == STEP_CYCLES-1, cnt wraps to 0 and a step occurs at that edge.
  - The first step lands exactly STEP_CYCLES edges after the load edge.
- Step, at the same edge as the led update; tick is registered and is 1 for exactly that cycle:
  - ROT_R: led <= {led[0], led[3:1]}, giving 0001 -> 1000 -> 0100 -> 0010 -> 0001.
  - ROT_L: led <= {led[2:0], led[3]}.
  - BLINK: led <= ~led.
  - PING with dir = up: shift left. The shift that reaches 1000 sets dir = down.
  - PING with dir = down: shift right. The shift that reaches 0001 sets dir = up.
  - PING never repeats an end position.
- Accept coinciding with a step edge: the command wins, the step is discarded and tick = 0.
- Held valid: a requester holding valid with ready high is accepted every cycle, so each cycle restarts its mode. Upstream must drop valid after acceptance.
- Reset mid-operation: all state returns to reset values on the next edge. An in-flight command is not accepted (ready = 0) and must be re-presented.

Test Plan (STEP_CYCLES = 4):
- Release reset, no commands, run 13 cycles -> led 0001 until edge 4, then 1000 @4, 0100 @8, 0010 @12; tick high only for those cycles; mode = 1 throughout.
- a_valid = 1 with a_cmd = 3 and b_valid = 1 with b_cmd = 2 in the same cycle, drop a_valid the next cycle -> b_ready = 0 in the first cycle, A accepted (led 1111); B accepted the next cycle (led 0001, mode 2); led 0010 four edges later.
- Accept cmd 4, run 32 cycles -> led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, one change every 4 edges.
- During ROT_L at led 0100, accept cmd 6 -> cmd_err pulses for one cycle; led and mode unchanged; next step still at the original cadence, giving 1000.
- During ROT_L at 0100, accept cmd 5 and wait 20 cycles -> led stays 0100, tick stays 0, cnt stays 0. Then accept cmd 2 -> led 0001 immediately, 0010 after 4 edges.
- Mid-BLINK, assert sys_rst for 1 cycle with a_valid = 1 and a_cmd = 4 -> a_ready = 0 during reset; next state is mode 1, led 0001, no PING entry. Also accept a command on exactly the step edge -> entry pattern loaded, tick = 0.

Source files
------------

// File: rtl/led_mode_ctrl_if.sv
// Command bus for led_mode_ctrl: two requesters, each with valid/cmd/ready.
// Requester A has fixed priority over requester B.
//
// Signals:
//   a_valid, a_cmd[2:0], a_ready : requester A handshake and command code
//   b_valid, b_cmd[2:0], b_ready : requester B handshake and command code
// Modports:
//   master : requester side (drives valid/cmd, sees ready)
//   slave  : controller side (sees valid/cmd, drives ready)
interface led_mode_ctrl_if;
    logic       a_valid;
    logic [2:0] a_cmd;
    logic       a_ready;
    logic       b_valid;
    logic [2:0] b_cmd;
    logic       b_ready;

    modport master (
        output a_valid,
        output a_cmd,
        input  a_ready,
        output b_valid,
        output b_cmd,
        input  b_ready
    );

    modport slave (
        input  a_valid,
        input  a_cmd,
        output a_ready,
        input  b_valid,
        input  b_cmd,
        output b_ready
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// 4-LED mode controller: fixed-priority command arbiter, step prescaler
// and LED pattern sequencer (rotate R/L, blink, ping-pong, hold, off).
//
// Ports:
//   sys_clk     : system clock, rising edge
//   sys_rst     : synchronous active-high reset
//   bus (slave) : requester A/B command handshakes (A has priority)
//   led[3:0]    : LED drive, 1 = on
//   mode[2:0]   : current mode code
//   tick        : one-cycle pulse on each pattern step
//   cmd_err     : one-cycle pulse after an illegal command is accepted
module led_mode_ctrl #(
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    led_mode_ctrl_if.slave  bus,
    output logic [3:0]      led,
    output logic [2:0]      mode,
    output logic            tick,
    output logic            cmd_err
);

    localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        M_OFF   = 3'd0,
        M_ROT_R = 3'd1,
        M_ROT_L = 3'd2,
        M_BLINK = 3'd3,
        M_PING  = 3'd4,
        M_HOLD  = 3'd5
    } mode_e;

    mode_e            r_mode;
    logic [3:0]       r_led;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir_up;
    logic             r_tick;
    logic             r_err;

    mode_e            w_mode_n;
    logic [3:0]       w_led_n;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_dir_up_n;
    logic             w_tick_n;
    logic             w_err_n;

    logic             w_acc_a;
    logic             w_acc_b;
    logic             w_acc;
    logic [2:0]       w_cmd;
    logic             w_legal;
    logic             w_run;
    logic             w_wrap;
    logic [3:0]       w_led_shl;
    logic [3:0]       w_led_shr;

    // Ready is purely combinational; B is blocked whenever A is asking.
    assign bus.a_ready = !sys_rst;
    assign bus.b_ready = !sys_rst && !bus.a_valid;

    assign w_acc_a = bus.a_valid && bus.a_ready;
    assign w_acc_b = bus.b_valid && bus.b_ready;
    assign w_acc   = w_acc_a || w_acc_b;
    assign w_cmd   = w_acc_a ? bus.a_cmd : bus.b_cmd;
    assign w_legal = (w_cmd <= 3'd5);

    assign w_run = (r_mode == M_ROT_R) || (r_mode == M_ROT_L) ||
                   (r_mode == M_BLINK) || (r_mode == M_PING);
    assign w_wrap = w_run && (r_cnt == CNT_LAST);

    assign w_led_shl = {r_led[2:0], 1'b0};
    assign w_led_shr = {1'b0, r_led[3:1]};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_mode   <= M_ROT_R;
            r_led    <= 4'b0001;
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
            r_tick   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_mode   <= w_mode_n;
            r_led    <= w_led_n;
            r_cnt    <= w_cnt_n;
            r_dir_up <= w_dir_up_n;
            r_tick   <= w_tick_n;
            r_err    <= w_err_n;
        end
    end

    always_comb begin
        w_mode_n   = r_mode;
        w_led_n    = r_led;
        w_cnt_n    = '0;
        w_dir_up_n = r_dir_up;
        w_tick_n   = 1'b0;
        w_err_n    = 1'b0;

        if (w_run) begin
            w_cnt_n = w_wrap ? '0 : r_cnt + CNT_W'(1);
        end

        if (w_acc && w_legal) begin
            // A legal command always restarts from its entry pattern,
            // and swallows any step due on this edge.
            w_mode_n   = mode_e'(w_cmd);
            w_cnt_n    = '0;
            w_dir_up_n = 1'b1;
            case (mode_e'(w_cmd))
                M_OFF:   w_led_n = 4'b0000;
                M_ROT_R: w_led_n = 4'b0001;
                M_ROT_L: w_led_n = 4'b0001;
                M_BLINK: w_led_n = 4'b1111;
                M_PING:  w_led_n = 4'b0001;
                default: w_led_n = r_led;
            endcase
        end else begin
            // An illegal command only flags; the sequence runs on.
            w_err_n = w_acc;
            if (w_wrap) begin
                w_tick_n = 1'b1;
                case (r_mode)
                    M_ROT_R: w_led_n = {r_led[0], r_led[3:1]};
                    M_ROT_L: w_led_n = {r_led[2:0], r_led[3]};
                    M_BLINK: w_led_n = ~r_led;
                    M_PING: begin
                        if (r_dir_up) begin
                            w_led_n = w_led_shl;
                            if (w_led_shl == 4'b1000) begin
                                w_dir_up_n = 1'b0;
                            end
                        end else begin
                            w_led_n = w_led_shr;
                            if (w_led_shr == 4'b0001) begin
                                w_dir_up_n = 1'b1;
                            end
                        end
                    end
                    default: w_led_n = r_led;
                endcase
            end
        end
    end

    assign led     = r_led;
    assign mode    = r_mode;
    assign tick    = r_tick;
    assign cmd_err = r_err;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl (STEP_CYCLES = 4).
// Reference model: time since mode load indexes a per-mode pattern table.
module tb_led_mode_ctrl;

    localparam int S = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] led;
    logic [2:0] mode;
    logic       tick;
    logic       cmd_err;

    led_mode_ctrl_if bus ();

    led_mode_ctrl #(.STEP_CYCLES(S)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus),
        .led     (led),
        .mode    (mode),
        .tick    (tick),
        .cmd_err (cmd_err)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    // Model state: mode, edges since load, frozen pattern for HOLD.
    int         m_mode = 1;
    int         m_age  = 0;
    logic [3:0] m_held = 4'b0001;
    logic       m_tick = 1'b0;
    logic       m_err  = 1'b0;

    logic [3:0] T_ROTR [4] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
    logic [3:0] T_ROTL [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] T_BLNK [2] = '{4'b1111, 4'b0000};
    logic [3:0] T_PING [6] = '{4'b0001, 4'b0010, 4'b0100,
                               4'b1000, 4'b0100, 4'b0010};

    function automatic logic [3:0] exp_led();
        int k;
        k = m_age / S;
        case (m_mode)
            1:       return T_ROTR[k % 4];
            2:       return T_ROTL[k % 4];
            3:       return T_BLNK[k % 2];
            4:       return T_PING[k % 6];
            5:       return m_held;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit running();
        return (m_mode >= 1) && (m_mode <= 4);
    endfunction

    task automatic set_in(input logic r, input logic av,
                          input logic [2:0] ac, input logic bv,
                          input logic [2:0] bc);
        sys_rst     = r;
        bus.a_valid = av;
        bus.a_cmd   = ac;
        bus.b_valid = bv;
        bus.b_cmd   = bc;
    endtask

    // Advance one rising edge and update the model from the applied inputs.
    task automatic edge_model();
        logic aa;
        logic ba;
        logic [2:0] c;
        @(posedge sys_clk);
        aa = !sys_rst && bus.a_valid;
        ba = !sys_rst && bus.b_valid && !bus.a_valid;
        c  = aa ? bus.a_cmd : bus.b_cmd;
        if (sys_rst) begin
            m_mode = 1; m_age = 0; m_held = 4'b0001;
            m_tick = 0; m_err = 0;
        end else if ((aa || ba) && c <= 3'd5) begin
            if (c == 3'd5) m_held = exp_led();
            m_mode = int'(c); m_age = 0; m_tick = 0; m_err = 0;
        end else begin
            if (running()) m_age++;
            m_err  = aa || ba;
            m_tick = running() && m_age > 0 && (m_age % S) == 0;
        end
        @(negedge sys_clk);
    endtask

    task automatic cyc(input logic r, input logic av, input logic [2:0] ac,
                       input logic bv, input logic [2:0] bc);
        set_in(r, av, ac, bv, bc);
        edge_model();
    endtask

    task automatic test_reset();
        set_in(1, 1, 3'd3, 1, 3'd2);
        #1;
        checks++;
        if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%b b=%b want 0 0",
                     bus.a_ready, bus.b_ready);
        end
        edge_model();
        edge_model();
        checks++;
        if (led !== 4'b0001 || mode !== 3'd1 || tick !== 0 || cmd_err !== 0) begin
            errors++;
            $display("FAIL reset_state: got led=%b mode=%0d tick=%b err=%b want 0001 1 0 0",
                     led, mode, tick, cmd_err);
        end
    endtask

    task automatic test_rot_r();
        logic [3:0] want;
        for (int i = 1; i <= 13; i++) begin
            cyc(0, 0, 0, 0, 0);
            want = T_ROTR[(i / 4) % 4];
            checks++;
            if (led !== want || tick !== (i % 4 == 0) || mode !== 3'd1) begin
                errors++;
                $display("FAIL rot_r edge %0d: got led=%b tick=%b mode=%0d want %b %b 1",
                         i, led, tick, mode, want, i % 4 == 0);
            end
        end
    endtask

    task automatic test_priority();
        set_in(0, 1, 3'd3, 1, 3'd2);
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ready: got a=%b b=%b want 1 0",
                     bus.a_ready, bus.b_ready);
        end
        edge_model();
        checks++;
        if (led !== 4'b1111 || mode !== 3'd3) begin
            errors++;
            $display("FAIL prio_a: got led=%b mode=%0d want 1111 3", led, mode);
        end
        set_in(0, 0, 3'd3, 1, 3'd2);
        #1;
        checks++;
        if (bus.b_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_bready: got %b want 1", bus.b_ready);
        end
        edge_model();
        checks++;
        if (led !== 4'b0001 || mode !== 3'd2) begin
            errors++;
            $display("FAIL prio_b: got led=%b mode=%0d want 0001 2", led, mode);
        end
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 0, 0);
        checks++;
        if (led !== 4'b0010 || led !== exp_led()) begin
            errors++;
            $display("FAIL prio_step: got led=%b want 0010", led);
        end
    endtask

    task automatic test_ping();
        logic [3:0] seq [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                4'b0010, 4'b0001, 4'b0010, 4'b0100};
        cyc(0, 1, 3'd4, 0, 0);
        for (int i = 1; i <= 32; i++) begin
            cyc(0, 0, 0, 0, 0);
            checks++;
            if (led !== seq[i / 4] || led !== exp_led() || tick !== m_tick) begin
                errors++;
                $display("FAIL ping edge %0d: got led=%b tick=%b want %b %b",
                         i, led, tick, seq[i / 4], m_tick);
            end
        end
    endtask

    task automatic test_illegal();
        cyc(0, 0, 0, 1, 3'd2);
        for (int i = 1; i <= 8; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 3'd6, 0, 0);
        checks++;
        if (cmd_err !== 1'b1 || led !== 4'b0100 || mode !== 3'd2) begin
            errors++;
            $display("FAIL illegal_accept: got err=%b led=%b mode=%0d want 1 0100 2",
                     cmd_err, led, mode);
        end
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_pulse: got err=%b want 0", cmd_err);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        checks++;
        if (led !== 4'b1000 || tick !== 1'b1) begin
            errors++;
            $display("FAIL illegal_cadence: got led=%b tick=%b want 1000 1", led, tick);
        end
    endtask

    task automatic test_hold();
        cyc(0, 1, 3'd2, 0, 0);
        for (int i = 1; i <= 8; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3'd5);
        for (int i = 1; i <= 20; i++) begin
            cyc(0, 0, 0, 0, 0);
            checks++;
            if (led !== 4'b0100 || tick !== 0 || mode !== 3'd5 || dut.r_cnt !== '0) begin
                errors++;
                $display("FAIL hold cycle %0d: got led=%b tick=%b mode=%0d cnt=%0d want 0100 0 5 0",
                         i, led, tick, mode, dut.r_cnt);
            end
        end
        cyc(0, 1, 3'd2, 0, 0);
        checks++;
        if (led !== 4'b0001 || mode !== 3'd2) begin
            errors++;
            $display("FAIL hold_exit: got led=%b mode=%0d want 0001 2", led, mode);
        end
        for (int i = 1; i <= 4; i++) cyc(0, 0, 0, 0, 0);
        checks++;
        if (led !== 4'b0010) begin
            errors++;
            $display("FAIL hold_exit_step: got led=%b want 0010", led);
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 3'd3, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        set_in(1, 1, 3'd4, 0, 0);
        #1;
        checks++;
        if (bus.a_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready: got %b want 0", bus.a_ready);
        end
        edge_model();
        checks++;
        if (mode !== 3'd1 || led !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_state: got mode=%0d led=%b want 1 0001", mode, led);
        end
        for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 0, 0);
        checks++;
        if (mode !== 3'd1 || led !== 4'b0001 || tick !== 0) begin
            errors++;
            $display("FAIL rstmid_noping: got mode=%0d led=%b tick=%b want 1 0001 0",
                     mode, led, tick);
        end
        // Fourth edge after reset would be a step; the command must win.
        cyc(0, 1, 3'd3, 0, 0);
        checks++;
        if (led !== 4'b1111 || tick !== 1'b0 || mode !== 3'd3) begin
            errors++;
            $display("FAIL step_edge_accept: got led=%b tick=%b mode=%0d want 1111 0 3",
                     led, tick, mode);
        end
    endtask

    task automatic test_random();
        logic r, av, bv;
        logic [2:0] ac, bc;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            av = ($urandom_range(0, 9) == 0);
            bv = ($urandom_range(0, 7) == 0);
            ac = 3'($urandom_range(0, 7));
            bc = 3'($urandom_range(0, 7));
            set_in(r, av, ac, bv, bc);
            #1;
            checks++;
            if (bus.a_ready !== !r || bus.b_ready !== (!r && !av)) begin
                errors++;
                $display("FAIL rand_ready %0d: got a=%b b=%b want %b %b",
                         i, bus.a_ready, bus.b_ready, !r, !r && !av);
            end
            edge_model();
            checks++;
            if (led !== exp_led() || mode !== 3'(m_mode) ||
                tick !== m_tick || cmd_err !== m_err) begin
                errors++;
                $display("FAIL rand %0d: got led=%b mode=%0d tick=%b err=%b want %b %0d %b %b",
                         i, led, mode, tick, cmd_err, exp_led(), m_mode, m_tick, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rot_r();
        test_priority();
        test_ping();
        test_illegal();
        test_hold();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
